// File: rtl/stage_execute_md_pkg.sv
// Shared types and encodings for the execute stage with iterative multiply/divide.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6,
    MD_MTHI  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  function automatic logic is_start_op(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/stage_execute_md_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  md_op_t           w_op;
  md_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_ph, r_pl, r_opb;
  logic             r_div, r_neg_q, r_neg_r;

  logic             w_signed, w_is_div, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_op     = md_op_t'(op);
  assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // r_ph/r_pl form one double-width shift register: product high/low for
  // multiply, remainder/dividend-becoming-quotient for divide.
  logic [WIDTH:0]     w_madd, w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_ph_n, w_pl_n;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0]   w_hi_fin, w_lo_fin;

  always_comb begin
    w_madd  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opb} : '0);
    w_shift = {r_ph, r_pl[WIDTH-1]};
    w_ge    = w_shift >= {1'b0, r_opb};
    w_trial = w_shift[WIDTH-1:0] - r_opb;
    if (r_div) begin
      w_ph_n = w_ge ? w_trial : w_shift[WIDTH-1:0];
      w_pl_n = {r_pl[WIDTH-2:0], w_ge};
    end else begin
      w_ph_n = w_madd[WIDTH:1];
      w_pl_n = {w_madd[0], r_pl[WIDTH-1:1]};
    end
    w_prod     = {w_ph_n, w_pl_n};
    w_prod_neg = -w_prod;
    if (r_div) begin
      w_lo_fin = r_neg_q ? -w_pl_n : w_pl_n;
      w_hi_fin = r_neg_r ? -w_ph_n : w_ph_n;
    end else if (r_neg_q) begin
      {w_hi_fin, w_lo_fin} = w_prod_neg;
    end else begin
      {w_hi_fin, w_lo_fin} = w_prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_opb   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (!flush) begin
            if (start) begin
              r_div   <= w_is_div;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CNT_LOAD;
              r_ph    <= '0;
              r_pl    <= w_is_div ? w_a_mag : w_b_mag;
              r_opb   <= w_is_div ? w_b_mag : w_a_mag;
              r_state <= MD_RUN;
            end else if (w_op == MD_MTHI) begin
              r_hi <= a;
            end
          end
        end
        MD_RUN: begin
          if (flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_ph  <= w_ph_n;
            r_pl  <= w_pl_n;
            r_cnt <= r_cnt - CNT_LAST;
            if (r_cnt == CNT_LAST) begin
              r_hi    <= w_hi_fin;
              r_lo    <= w_lo_fin;
              r_state <= MD_DONE;
            end
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Stall must drop while reset is held even if a start op sits at the input.
  assign busy = rst_n & (((r_state == MD_IDLE) & start & ~flush) | (r_state == MD_RUN));
  assign done = (r_state == MD_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/stage_execute_md.sv
// MIPS execute stage: bypass muxes, ALU, dest select, branch adder and md unit.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

module mux3
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (s)
      FWD_WB:  y = d1;
      FWD_MEM: y = d2;
      default: y = d0;
    endcase
  end
endmodule

module alu
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow
);
  logic [WIDTH-1:0] w_sum, w_diff;
  logic             w_lt;

  always_comb begin
    w_sum    = a + b;
    w_diff   = a - b;
    w_lt     = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : w_diff[WIDTH-1];
    y        = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD: begin
        y        = w_sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_ANDN: y = a & ~b;
      ALU_ORN:  y = a | ~b;
      ALU_SUB: begin
        y        = w_diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, w_lt};
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);
endmodule

module shiftleft2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = a << 2;
endmodule

module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a + b;
endmodule

module stage_execute_md
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_E,
  input  logic               alusrc,
  input  logic               regdst,
  input  logic [2:0]         alucontrol,
  input  logic [2:0]         md_op,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic [REGADDR-1:0] rt,
  input  logic [REGADDR-1:0] rd,
  input  logic [WIDTH-1:0]   signimm,
  input  logic [WIDTH-1:0]   pcplus4,
  input  logic [WIDTH-1:0]   aluresult_MEM,
  input  logic [WIDTH-1:0]   result_WB,
  input  logic [1:0]         forward_a,
  input  logic [1:0]         forward_b,
  output logic [WIDTH-1:0]   aluresult,
  output logic               zero,
  output logic               overflow,
  output logic [REGADDR-1:0] writereg,
  output logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   pcbranch,
  output logic               stall_md
);

  md_op_t           w_op;
  logic [WIDTH-1:0] w_srca, w_srcb, w_alu_y, w_immsh, w_hi, w_lo;
  logic             w_alu_zero, w_alu_ovf, w_md_busy, w_md_done;

  assign w_op = md_op_t'(md_op);

  mux3 #(.WIDTH(WIDTH)) u_fwd_a (
    .d0(reg1), .d1(result_WB), .d2(aluresult_MEM), .s(forward_a), .y(w_srca)
  );
  mux3 #(.WIDTH(WIDTH)) u_fwd_b (
    .d0(reg2), .d1(result_WB), .d2(aluresult_MEM), .s(forward_b), .y(writedata)
  );
  mux2 #(.WIDTH(WIDTH)) u_srcb (
    .d0(writedata), .d1(signimm), .s(alusrc), .y(w_srcb)
  );
  mux2 #(.WIDTH(REGADDR)) u_wreg (
    .d0(rt), .d1(rd), .s(regdst), .y(writereg)
  );
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(w_srca), .b(w_srcb), .ctrl(alucontrol),
    .y(w_alu_y), .zero(w_alu_zero), .overflow(w_alu_ovf)
  );
  shiftleft2 #(.WIDTH(WIDTH)) u_sl2 (
    .a(signimm), .y(w_immsh)
  );
  adder #(.WIDTH(WIDTH)) u_pcadd (
    .a(w_immsh), .b(pcplus4), .y(pcbranch)
  );

  muldiv_unit #(.WIDTH(WIDTH)) u_md (
    .clk  (clk),
    .rst_n(reset),
    .start(is_start_op(w_op)),
    .op   (md_op),
    .a    (w_srca),
    .b    (writedata),
    .flush(flush_E),
    .busy (w_md_busy),
    .done (w_md_done),
    .hi   (w_hi),
    .lo   (w_lo)
  );

  // The op is still presented during DONE; it must retire, never re-stall.
  assign stall_md = w_md_busy & ~w_md_done;

  always_comb begin
    aluresult = w_alu_y;
    zero      = w_alu_zero;
    overflow  = w_alu_ovf;
    case (w_op)
      MD_MFHI: begin
        aluresult = w_hi;
        zero      = 1'b0;
        overflow  = 1'b0;
      end
      MD_MFLO: begin
        aluresult = w_lo;
        zero      = 1'b0;
        overflow  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage_execute_md.sv
// Directed bench for stage_execute_md at WIDTH=32 plus a WIDTH=16 instance.
module tb_stage_execute_md;
  import md_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush_E, alusrc, regdst;
  logic [2:0]  alucontrol, md_op;
  logic [31:0] reg1, reg2, signimm, pcplus4, aluresult_MEM, result_WB;
  logic [4:0]  rt, rd, writereg;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] aluresult, writedata, pcbranch;
  logic        zero, overflow, stall_md;

  logic        s_flush_E, s_alusrc, s_regdst;
  logic [2:0]  s_alucontrol, s_md_op;
  logic [15:0] s_reg1, s_reg2, s_signimm, s_pcplus4, s_aluresult_MEM, s_result_WB;
  logic [4:0]  s_rt, s_rd, s_writereg;
  logic [1:0]  s_forward_a, s_forward_b;
  logic [15:0] s_aluresult, s_writedata, s_pcbranch;
  logic        s_zero, s_overflow, s_stall_md;

  stage_execute_md #(.WIDTH(32), .REGADDR(5)) u_dut (
    .clk(clk), .reset(reset), .flush_E(flush_E), .alusrc(alusrc), .regdst(regdst),
    .alucontrol(alucontrol), .md_op(md_op), .reg1(reg1), .reg2(reg2), .rt(rt), .rd(rd),
    .signimm(signimm), .pcplus4(pcplus4), .aluresult_MEM(aluresult_MEM),
    .result_WB(result_WB), .forward_a(forward_a), .forward_b(forward_b),
    .aluresult(aluresult), .zero(zero), .overflow(overflow), .writereg(writereg),
    .writedata(writedata), .pcbranch(pcbranch), .stall_md(stall_md)
  );

  stage_execute_md #(.WIDTH(16), .REGADDR(5)) u_dut16 (
    .clk(clk), .reset(reset), .flush_E(s_flush_E), .alusrc(s_alusrc), .regdst(s_regdst),
    .alucontrol(s_alucontrol), .md_op(s_md_op), .reg1(s_reg1), .reg2(s_reg2), .rt(s_rt),
    .rd(s_rd), .signimm(s_signimm), .pcplus4(s_pcplus4), .aluresult_MEM(s_aluresult_MEM),
    .result_WB(s_result_WB), .forward_a(s_forward_a), .forward_b(s_forward_b),
    .aluresult(s_aluresult), .zero(s_zero), .overflow(s_overflow), .writereg(s_writereg),
    .writedata(s_writedata), .pcbranch(s_pcbranch), .stall_md(s_stall_md)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  fa, fb;
    logic        asrc, rdst;
    logic [2:0]  ctrl;
    logic [31:0] r1, r2, simm, pc4, mem, wb;
    logic [4:0]  rt, rd;
    logic [31:0] ey;
    logic        ez, eo;
    logic [31:0] ewd;
    logic [4:0]  ewr;
    logic [31:0] epcb;
  } vec_t;

  vec_t vecs[8];

  // Drives one multi-cycle op, measures its stall, then reads HI/LO behind it.
  task automatic md_run(input string name, input md_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int ecyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc = 0;
    @(negedge clk);
    md_op = op; reg1 = a; reg2 = b; forward_a = FWD_REG; forward_b = FWD_REG;
    #1;
    while (stall_md === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, 32'(cyc), 32'(ecyc));
    @(posedge clk);
    #1;
    md_op = MD_MFHI;
    #1;
    chk({name, "_hi"}, aluresult, ehi);
    chk({name, "_no_restart"}, 32'(stall_md), 32'd0);
    chk({name, "_mfhi_zero"}, 32'(zero), 32'd0);
    md_op = MD_MFLO;
    #1;
    chk({name, "_lo"}, aluresult, elo);
    chk({name, "_mflo_ovf"}, 32'(overflow), 32'd0);
    md_op = MD_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0] = '{2'b10, 2'b01, 1'b0, 1'b0, ALU_ADD,  32'd1, 32'd2, 32'd0, 32'h100, 32'd5, 32'd9,
                5'd3, 5'd7, 32'd14, 1'b0, 1'b0, 32'd9, 5'd3, 32'h100};
    vecs[1] = '{2'b00, 2'b00, 1'b0, 1'b1, ALU_SUB,  32'd5, 32'd5, 32'd1, 32'h100, 32'd0, 32'd0,
                5'd3, 5'd7, 32'd0, 1'b1, 1'b0, 32'd5, 5'd7, 32'h104};
    vecs[2] = '{2'b11, 2'b00, 1'b1, 1'b0, ALU_ADD,  32'h7FFFFFFF, 32'h12345678, 32'd1, 32'h100,
                32'd0, 32'd0, 5'd1, 5'd2, 32'h80000000, 1'b0, 1'b1, 32'h12345678, 5'd1, 32'h104};
    vecs[3] = '{2'b00, 2'b11, 1'b0, 1'b1, ALU_SUB,  32'h80000000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
                5'd0, 5'd31, 32'h7FFFFFFF, 1'b0, 1'b1, 32'd1, 5'd31, 32'd0};
    vecs[4] = '{2'b00, 2'b00, 1'b0, 1'b0, ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'h10, 32'h200, 32'd0,
                32'd0, 5'd5, 5'd6, 32'd1, 1'b0, 1'b0, 32'd1, 5'd5, 32'h240};
    vecs[5] = '{2'b01, 2'b10, 1'b0, 1'b1, ALU_AND,  32'd0, 32'd0, 32'hFFFFFFFE, 32'h10, 32'hFF00,
                32'hF0F0, 5'd2, 5'd4, 32'hF000, 1'b0, 1'b0, 32'hFF00, 5'd4, 32'h8};
    vecs[6] = '{2'b00, 2'b00, 1'b1, 1'b0, ALU_OR,   32'd0, 32'd3, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd0,
                5'd9, 5'd10, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd3, 5'd9, 32'd0};
    vecs[7] = '{2'b00, 2'b00, 1'b0, 1'b0, ALU_ANDN, 32'hFF, 32'h0F, 32'd0, 32'd8, 32'd0, 32'd0,
                5'd11, 5'd12, 32'hF0, 1'b0, 1'b0, 32'h0F, 5'd11, 32'd8};

    reset = 1'b0; flush_E = 1'b0; alusrc = 1'b0; regdst = 1'b0; alucontrol = ALU_ADD;
    md_op = MD_MULT; reg1 = 32'd3; reg2 = 32'd4; signimm = '0; pcplus4 = '0;
    aluresult_MEM = '0; result_WB = '0; rt = '0; rd = '0; forward_a = FWD_REG; forward_b = FWD_REG;
    s_flush_E = 1'b0; s_alusrc = 1'b0; s_regdst = 1'b0; s_alucontrol = ALU_ADD; s_md_op = MD_NONE;
    s_reg1 = '0; s_reg2 = '0; s_signimm = '0; s_pcplus4 = '0; s_aluresult_MEM = '0;
    s_result_WB = '0; s_rt = '0; s_rd = '0; s_forward_a = FWD_REG; s_forward_b = FWD_REG;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall_with_start", 32'(stall_md), 32'd0);
    md_op = MD_MFHI;
    #1;
    chk("rst_hi", aluresult, 32'd0);
    md_op = MD_MFLO;
    #1;
    chk("rst_lo", aluresult, 32'd0);
    @(negedge clk);
    md_op = MD_NONE;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      forward_a = vecs[i].fa; forward_b = vecs[i].fb; alusrc = vecs[i].asrc;
      regdst = vecs[i].rdst; alucontrol = vecs[i].ctrl; reg1 = vecs[i].r1; reg2 = vecs[i].r2;
      signimm = vecs[i].simm; pcplus4 = vecs[i].pc4; aluresult_MEM = vecs[i].mem;
      result_WB = vecs[i].wb; rt = vecs[i].rt; rd = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_aluresult", i), aluresult, vecs[i].ey);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].ez));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].eo));
      chk($sformatf("v%0d_writedata", i), writedata, vecs[i].ewd);
      chk($sformatf("v%0d_writereg", i), 32'(writereg), 32'(vecs[i].ewr));
      chk($sformatf("v%0d_pcbranch", i), pcbranch, vecs[i].epcb);
      chk($sformatf("v%0d_no_stall", i), 32'(stall_md), 32'd0);
    end

    alusrc = 1'b0; alucontrol = ALU_ADD;
    md_run("mult",      MD_MULT,  32'hFFFFFFFD, 32'd7,        33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_run("div",       MD_DIV,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("div_pn",    MD_DIV,   32'd7,        32'hFFFFFFFE, 33, 32'd1,        32'hFFFFFFFD);
    md_run("divu",      MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);
    md_run("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'd0,        32'h80000000);
    md_run("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'd1);
    md_run("div0",      MD_DIV,   32'd5,        32'd0,        33, 32'd5,        32'hFFFFFFFF);

    // Flush in RUN cycle 10: HI/LO must keep the div0 results.
    @(negedge clk);
    md_op = MD_DIV; reg1 = 32'd100; reg2 = 32'd7;
    #1;
    chk("flush_start_stall", 32'(stall_md), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("flush_run10_stall", 32'(stall_md), 32'd1);
    flush_E = 1'b1;
    @(posedge clk);
    #1;
    flush_E = 1'b0; md_op = MD_MFHI;
    #1;
    chk("flush_stall_drop", 32'(stall_md), 32'd0);
    chk("flush_hi_kept", aluresult, 32'd5);
    md_op = MD_MFLO;
    #1;
    chk("flush_lo_kept", aluresult, 32'hFFFFFFFF);
    md_op = MD_NONE;

    // Flush while idle blocks a start.
    @(negedge clk);
    md_op = MD_MULT; reg1 = 32'd2; reg2 = 32'd2; flush_E = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(stall_md), 32'd0);
    @(posedge clk);
    #1;
    flush_E = 1'b0; md_op = MD_MFLO;
    #1;
    chk("flush_idle_stall_next", 32'(stall_md), 32'd0);
    chk("flush_idle_lo", aluresult, 32'hFFFFFFFF);

    @(negedge clk);
    md_op = MD_MTHI; reg1 = 32'hCAFEBABE;
    #1;
    chk("mthi_stall", 32'(stall_md), 32'd0);
    @(posedge clk);
    #1;
    md_op = MD_MFHI;
    #1;
    chk("mthi_hi", aluresult, 32'hCAFEBABE);
    md_op = MD_MFLO;
    #1;
    chk("mthi_lo_kept", aluresult, 32'hFFFFFFFF);
    md_op = MD_NONE;

    @(negedge clk);
    md_op = MD_MULT; reg1 = 32'd3; reg2 = 32'd5;
    repeat (4) @(negedge clk);
    #1;
    chk("rstrun_stall_before", 32'(stall_md), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstrun_stall", 32'(stall_md), 32'd0);
    md_op = MD_MFHI;
    #1;
    chk("rstrun_hi", aluresult, 32'd0);
    md_op = MD_MFLO;
    #1;
    chk("rstrun_lo", aluresult, 32'd0);
    @(negedge clk);
    reset = 1'b1; md_op = MD_NONE;
    #1;
    chk("rstrun_idle", 32'(stall_md), 32'd0);
    md_run("multu_after_rst", MD_MULTU, 32'd3, 32'd5, 33, 32'd0, 32'd15);

    // WIDTH=16 instance.
    @(negedge clk);
    s_md_op = MD_MULTU; s_reg1 = 16'hFFFF; s_reg2 = 16'hFFFF;
    s_signimm = 16'hFFFF; s_pcplus4 = 16'h0004;
    #1;
    chk("w16_pcbranch", 32'(s_pcbranch), 32'h0000);
    cyc = 0;
    while (s_stall_md === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("w16_stall_cycles", 32'(cyc), 32'd17);
    @(posedge clk);
    #1;
    s_md_op = MD_MFHI;
    #1;
    chk("w16_hi", 32'(s_aluresult), 32'hFFFE);
    s_md_op = MD_MFLO;
    #1;
    chk("w16_lo", 32'(s_aluresult), 32'h0001);
    s_md_op = MD_NONE;

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
